// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch port, data port and SRAM front-end request channel
// that surround the two-port SRAM arbiter.
interface sram_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_rw;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        mem_valid;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [15:0] mem_dtw;
  logic [15:0] mem_dtr;
  logic        mem_done;

  logic        busy;

  // The arbiter itself.
  modport slave (
    input  i_req, i_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_dtr, mem_done,
    output i_ack, i_rdata, d_ack, d_rdata, mem_valid, mem_rw, mem_addr, mem_dtw, busy
  );

  // The surroundings: CPU ports and the SRAM front-end.
  modport master (
    output i_req, i_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_dtr, mem_done,
    input  i_ack, i_rdata, d_ack, d_rdata, mem_valid, mem_rw, mem_addr, mem_dtw, busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter between fetch and data ports in front of the 16-bit SRAM
// front-end; splits 32-bit requests into SRAM beats and reassembles read data.
module sram_arbiter #(
  parameter int DRAIN_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {S_DRAIN, S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;
  localparam int   DRAIN_LAST  = (DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0;
  localparam int   CW          = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state_reg, state_next;
  logic [CW-1:0] drain_cnt_reg;
  logic [1:0]    b_reg, b_next;
  logic          last_grant_reg, grant_reg;
  logic          req_rw_reg;
  logic [1:0]    req_size_reg;
  logic [31:0]   req_addr_reg, req_wdata_reg;
  logic          wait_first_reg;
  logic          mem_rw_reg;
  logic [31:0]   mem_addr_reg;
  logic [15:0]   mem_dtw_reg;
  logic [15:0]   lo_reg;
  logic [31:0]   i_rdata_reg, d_rdata_reg;

  logic          start, load_beat, accept;
  logic          grant_d_idle, src_grant, src_rw;
  logic [1:0]    src_size, beat_idx, last_b;
  logic [31:0]   src_addr, src_wdata, beat_addr, rd_result;
  logic [15:0]   beat_dtw;
  logic [7:0]    wbyte [4];

  // In IDLE the beat is built straight from the winning port; afterwards from
  // the latched copy, so a port dropping its request cannot corrupt the beats.
  always_comb begin
    grant_d_idle = bus.d_req && (!bus.i_req || (last_grant_reg == GRANT_FETCH));
    src_grant    = grant_reg;
    src_rw       = req_rw_reg;
    src_size     = req_size_reg;
    src_addr     = req_addr_reg;
    src_wdata    = req_wdata_reg;
    beat_idx     = b_reg + 2'd1;
    if (state_reg == S_IDLE) begin
      beat_idx  = 2'd0;
      src_grant = grant_d_idle ? GRANT_DATA : GRANT_FETCH;
      if (grant_d_idle) begin
        src_rw    = bus.d_rw;
        src_size  = bus.d_size;
        src_addr  = bus.d_addr;
        src_wdata = bus.d_wdata;
      end else begin
        src_rw    = 1'b0;
        src_size  = 2'b10;
        src_addr  = bus.i_addr;
        src_wdata = 32'd0;
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_wbyte
    assign wbyte[gi] = src_wdata[8*gi +: 8];
  end

  // Writes go one byte lane per beat, so the byte is mirrored on both lanes.
  always_comb begin
    beat_addr = src_addr;
    if (!src_rw)
      beat_addr = src_size[1] ? {src_addr[31:2], beat_idx[0], 1'b0} : {src_addr[31:1], 1'b0};
    else if (src_size[1])
      beat_addr = {src_addr[31:2], 2'b00} + {30'd0, beat_idx};
    else if (src_size == 2'b01)
      beat_addr = {src_addr[31:1], 1'b0} + {30'd0, beat_idx};
    beat_dtw = 16'd0;
    if (src_rw)
      beat_dtw = {2{wbyte[(src_size == 2'b00) ? 2'd0 : beat_idx]}};
  end

  always_comb begin
    if (!req_rw_reg)
      last_b = req_size_reg[1] ? 2'd1 : 2'd0;
    else if (req_size_reg[1])
      last_b = 2'd3;
    else
      last_b = (req_size_reg == 2'b01) ? 2'd1 : 2'd0;

    if (req_size_reg[1])
      rd_result = {bus.mem_dtr, lo_reg};
    else if (req_size_reg == 2'b01)
      rd_result = {16'd0, bus.mem_dtr};
    else
      rd_result = {24'd0, req_addr_reg[0] ? bus.mem_dtr[15:8] : bus.mem_dtr[7:0]};
  end

  always_comb begin
    state_next = state_reg;
    b_next     = b_reg;
    start      = 1'b0;
    load_beat  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      S_DRAIN: if (drain_cnt_reg == CW'(DRAIN_LAST)) state_next = S_IDLE;
      S_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          start      = 1'b1;
          load_beat  = 1'b1;
          b_next     = 2'd0;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        // A done in the first WAIT cycle belongs to nothing we issued.
        if (bus.mem_done && !wait_first_reg) begin
          accept = 1'b1;
          if (b_reg == last_b) begin
            state_next = S_ACK;
          end else begin
            b_next     = b_reg + 2'd1;
            load_beat  = 1'b1;
            state_next = S_ISSUE;
          end
        end
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_DRAIN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_DRAIN;
      drain_cnt_reg  <= '0;
      b_reg          <= 2'd0;
      last_grant_reg <= GRANT_FETCH;
      grant_reg      <= GRANT_FETCH;
      req_rw_reg     <= 1'b0;
      req_size_reg   <= 2'b00;
      req_addr_reg   <= 32'd0;
      req_wdata_reg  <= 32'd0;
      wait_first_reg <= 1'b0;
      mem_rw_reg     <= 1'b0;
      mem_addr_reg   <= 32'd0;
      mem_dtw_reg    <= 16'd0;
      lo_reg         <= 16'd0;
      i_rdata_reg    <= 32'd0;
      d_rdata_reg    <= 32'd0;
    end else begin
      state_reg      <= state_next;
      b_reg          <= b_next;
      wait_first_reg <= (state_reg == S_ISSUE);
      if (state_reg == S_DRAIN)
        drain_cnt_reg <= drain_cnt_reg + CW'(1);
      if (start) begin
        grant_reg     <= src_grant;
        req_rw_reg    <= src_rw;
        req_size_reg  <= src_size;
        req_addr_reg  <= src_addr;
        req_wdata_reg <= src_wdata;
      end
      if (load_beat) begin
        mem_rw_reg   <= src_rw;
        mem_addr_reg <= beat_addr;
        mem_dtw_reg  <= beat_dtw;
      end
      if (accept) begin
        if (b_reg == 2'd0)
          lo_reg <= bus.mem_dtr;
        if (b_reg == last_b) begin
          if (grant_reg == GRANT_FETCH)
            i_rdata_reg <= rd_result;
          else if (!req_rw_reg)
            d_rdata_reg <= rd_result;
        end
      end
      if (state_reg == S_ACK)
        last_grant_reg <= grant_reg;
    end
  end

  assign bus.mem_valid = (state_reg == S_ISSUE);
  assign bus.mem_rw    = mem_rw_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_dtw   = mem_dtw_reg;
  assign bus.i_ack     = (state_reg == S_ACK) && (grant_reg == GRANT_FETCH);
  assign bus.d_ack     = (state_reg == S_ACK) && (grant_reg == GRANT_DATA);
  assign bus.i_rdata   = i_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM front-end model with a beat scoreboard, plus
// per-scenario tasks checking acks, latency, read data and arbitration.
module tb_sram_arbiter;
  localparam int DRAIN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if bus ();
  sram_arbiter #(.DRAIN_CYCLES(DRAIN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [15:0] dtw;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] rd_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          stale_en = 1'b0;

  task automatic exp_beat(input logic rw, input logic [31:0] addr, input logic [15:0] dtw);
    beat_t e;
    e.rw = rw; e.addr = addr; e.dtw = dtw;
    exp_q.push_back(e);
  endtask

  // SRAM front-end model: done 4 cycles after each strobe, optional stale done
  // in the first WAIT cycle; also scoreboards every issued beat.
  initial begin
    int          cnt;
    logic        h_rw;
    logic [31:0] h_addr;
    logic [15:0] h_dtw;
    beat_t       e;
    cnt = 0; h_rw = 0; h_addr = 0; h_dtw = 0;
    bus.mem_done = 1'b0;
    bus.mem_dtr  = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        cnt = 0;
        bus.mem_done = 1'b0;
      end else if (bus.mem_valid) begin
        if (cnt != 0) begin
          miscompares++;
          $display("FAIL valid_in_wait: mem_valid=1 with %0d cycles of beat left, required 0", cnt);
        end
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: rw=%0b addr=%h dtw=%h, required no beat", bus.mem_rw, bus.mem_addr, bus.mem_dtw);
        end else begin
          e = exp_q.pop_front();
          if ({bus.mem_rw, bus.mem_addr, bus.mem_dtw} !== {e.rw, e.addr, e.dtw}) begin
            miscompares++;
            $display("FAIL beat: rw=%0b addr=%h dtw=%h, required rw=%0b addr=%h dtw=%h",
                     bus.mem_rw, bus.mem_addr, bus.mem_dtw, e.rw, e.addr, e.dtw);
          end else
            $display("beat rw=%0b addr=%h dtw=%h", bus.mem_rw, bus.mem_addr, bus.mem_dtw);
        end
        h_rw = bus.mem_rw; h_addr = bus.mem_addr; h_dtw = bus.mem_dtw;
        cnt = 4;
        bus.mem_done = 1'b0;
      end else if (cnt > 0) begin
        if ({bus.mem_rw, bus.mem_addr, bus.mem_dtw} !== {h_rw, h_addr, h_dtw}) begin
          miscompares++;
          $display("FAIL hold: rw=%0b addr=%h dtw=%h, required rw=%0b addr=%h dtw=%h",
                   bus.mem_rw, bus.mem_addr, bus.mem_dtw, h_rw, h_addr, h_dtw);
        end
        cnt--;
        if (cnt == 0) begin
          bus.mem_done = 1'b1;
          bus.mem_dtr  = (rd_q.size() != 0) ? rd_q.pop_front() : 16'h0000;
        end else if (stale_en && cnt == 3) begin
          bus.mem_done = 1'b1;
          bus.mem_dtr  = 16'hFFFF;
        end else
          bus.mem_done = 1'b0;
      end else
        bus.mem_done = 1'b0;
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL %s_idle_timeout: busy=%0b, required 0 within 200 cycles", name, bus.busy);
    end
  endtask

  task automatic do_req(input bit is_d, input logic rw, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input bit chk_rd, input logic [31:0] exp_rd, input int exp_lat,
                        input string name);
    int cyc;
    bit got;
    logic [31:0] rd;
    wait_idle(name);
    if (is_d) begin
      bus.d_rw = rw; bus.d_size = size; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
    end else begin
      bus.i_addr = addr; bus.i_req = 1'b1;
    end
    cyc = 0; got = 0; rd = 0;
    while (!got && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if ((is_d ? bus.i_ack : bus.d_ack) === 1'b1) begin
        vectors++; miscompares++;
        $display("FAIL %s_wrong_ack: other port acked at cycle %0d, required none", name, cyc);
      end
      if ((is_d ? bus.d_ack : bus.i_ack) === 1'b1) begin
        got = 1;
        rd  = is_d ? bus.d_rdata : bus.i_rdata;
      end
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s_timeout: no ack in 100 cycles, required ack at %0d", name, exp_lat);
    end else if (cyc !== exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: ack at %0d, required %0d", name, cyc, exp_lat);
    end
    if (chk_rd) begin
      vectors++;
      if (rd !== exp_rd) begin
        miscompares++;
        $display("FAIL %s_rdata: got %h, required %h", name, rd, exp_rd);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if ({bus.i_ack, bus.d_ack} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s_ack_pulse: acks=%b one cycle later, required 00", name, {bus.i_ack, bus.d_ack});
    end
    $display("txn %s: ack after %0d cycles, rdata %h", name, cyc, rd);
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if ({bus.i_ack, bus.d_ack, bus.i_rdata, bus.d_rdata, bus.mem_valid, bus.mem_rw, bus.mem_addr, bus.mem_dtw} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: i_rdata=%h d_rdata=%h mem_addr=%h mem_valid=%0b, required all 0",
               bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_valid);
    end
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_busy: busy=%0b in DRAIN, required 1", bus.busy);
    end
    rst = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    vectors++;
    if (n !== DRAIN) begin
      miscompares++;
      $display("FAIL drain_len: busy for %0d cycles after reset, required %0d", n, DRAIN);
    end
    $display("txn reset: drain lasted %0d cycles", n);
  endtask

  task automatic test_fetch;
    rd_q.push_back(16'h1234); rd_q.push_back(16'hABCD);
    exp_beat(0, 32'h100, 16'h0); exp_beat(0, 32'h102, 16'h0);
    do_req(0, 0, 2'b10, 32'h100, 32'h0, 1, 32'hABCD1234, 11, "fetch_100");
    rd_q.push_back(16'h5555); rd_q.push_back(16'h6666);
    exp_beat(0, 32'h1FC, 16'h0); exp_beat(0, 32'h1FE, 16'h0);
    do_req(0, 0, 2'b10, 32'h1FF, 32'h0, 1, 32'h66665555, 11, "fetch_unaligned");
  endtask

  task automatic test_writes;
    exp_beat(1, 32'h200, 16'hAAAA); exp_beat(1, 32'h201, 16'hBBBB);
    exp_beat(1, 32'h202, 16'hCCCC); exp_beat(1, 32'h203, 16'hDDDD);
    do_req(1, 1, 2'b10, 32'h203, 32'hDDCCBBAA, 0, 32'h0, 21, "write_word");
    exp_beat(1, 32'h102, 16'hEFEF); exp_beat(1, 32'h103, 16'hBEBE);
    do_req(1, 1, 2'b01, 32'h103, 32'hFFFFBEEF, 0, 32'h0, 11, "write_half");
    exp_beat(1, 32'h7, 16'h7777);
    do_req(1, 1, 2'b00, 32'h7, 32'hAABBCC77, 0, 32'h0, 6, "write_byte");
  endtask

  task automatic test_reads;
    rd_q.push_back(16'h5A3C); exp_beat(0, 32'h30, 16'h0);
    do_req(1, 0, 2'b00, 32'h31, 32'h0, 1, 32'h0000005A, 6, "read_byte_odd");
    rd_q.push_back(16'h5A3C); exp_beat(0, 32'h30, 16'h0);
    do_req(1, 0, 2'b00, 32'h30, 32'h0, 1, 32'h0000003C, 6, "read_byte_even");
    rd_q.push_back(16'h5A3C); exp_beat(0, 32'h30, 16'h0);
    do_req(1, 0, 2'b01, 32'h30, 32'h0, 1, 32'h00005A3C, 6, "read_half");
    rd_q.push_back(16'h1111); rd_q.push_back(16'h2222);
    exp_beat(0, 32'h40, 16'h0); exp_beat(0, 32'h42, 16'h0);
    do_req(1, 0, 2'b10, 32'h41, 32'h0, 1, 32'h22221111, 11, "read_word");
    rd_q.push_back(16'h3333); rd_q.push_back(16'h4444);
    exp_beat(0, 32'h80, 16'h0); exp_beat(0, 32'h82, 16'h0);
    do_req(1, 0, 2'b11, 32'h80, 32'h0, 1, 32'h44443333, 11, "read_size11");
  endtask

  task automatic test_stale_done;
    stale_en = 1'b1;
    rd_q.push_back(16'h5A3C); exp_beat(0, 32'h30, 16'h0);
    do_req(1, 0, 2'b00, 32'h31, 32'h0, 1, 32'h0000005A, 6, "stale_byte");
    rd_q.push_back(16'h0102); rd_q.push_back(16'h0304);
    exp_beat(0, 32'h500, 16'h0); exp_beat(0, 32'h502, 16'h0);
    do_req(0, 0, 2'b10, 32'h500, 32'h0, 1, 32'h03040102, 11, "stale_fetch");
    stale_en = 1'b0;
  endtask

  task automatic test_back_to_back;
    int  cyc, acks;
    bit  prev_ack, want_d;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    wait_idle("b2b_drain");
    for (int k = 0; k < 2; k++) begin
      exp_beat(0, 32'h30, 16'h0);
      exp_beat(0, 32'h100, 16'h0); exp_beat(0, 32'h102, 16'h0);
    end
    bus.d_rw = 0; bus.d_size = 2'b00; bus.d_addr = 32'h31; bus.d_wdata = 0; bus.i_addr = 32'h100;
    bus.d_req = 1'b1; bus.i_req = 1'b1;
    cyc = 0; acks = 0; prev_ack = 0;
    while (acks < 4 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (prev_ack) begin
        vectors++;
        if (bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_gap: busy=%0b after ack %0d, required 0 (IDLE)", bus.busy, acks);
        end
      end
      prev_ack = 0;
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        want_d = (acks % 2 == 0);
        vectors++;
        if ({bus.d_ack, bus.i_ack} !== {want_d, !want_d}) begin
          miscompares++;
          $display("FAIL b2b_grant%0d: acks d=%0b i=%0b, required d=%0b i=%0b",
                   acks, bus.d_ack, bus.i_ack, want_d, !want_d);
        end else
          $display("txn b2b grant %0d: %s at cycle %0d", acks, want_d ? "D" : "I", cyc);
        acks++;
        prev_ack = 1;
      end
    end
    bus.d_req = 1'b0; bus.i_req = 1'b0;
    if (acks < 4) begin
      vectors++; miscompares++;
      $display("FAIL b2b_timeout: %0d acks in 300 cycles, required 4", acks);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_gap_last: busy=%0b after last ack, required 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid;
    int  n, valids;
    bit  saw_dack, got;
    wait_idle("mid");
    exp_beat(1, 32'h200, 16'hAAAA); exp_beat(1, 32'h201, 16'hBBBB);
    bus.d_rw = 1; bus.d_size = 2'b10; bus.d_addr = 32'h200; bus.d_wdata = 32'hDDCCBBAA;
    bus.i_addr = 32'h300;
    bus.d_req = 1'b1;
    n = 0; valids = 0; saw_dack = 0;
    while (valids < 2 && n < 100) begin
      @(posedge clk); #1; n++;
      if (bus.mem_valid === 1'b1) begin valids++; bus.i_req = 1'b1; end
      if (bus.d_ack === 1'b1) saw_dack = 1;
    end
    repeat (2) begin @(posedge clk); #1; if (bus.d_ack === 1'b1) saw_dack = 1; end
    rst = 1'b1;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    vectors++;
    if ({bus.i_ack, bus.d_ack, bus.i_rdata, bus.d_rdata, bus.mem_valid, bus.mem_rw, bus.mem_addr, bus.mem_dtw} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: i_rdata=%h d_rdata=%h mem_addr=%h mem_dtw=%h, required all 0",
               bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_dtw);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL mid_beats: %0d expected beats not issued, required 0", exp_q.size());
    end
    rst = 1'b0;
    rd_q.push_back(16'h0BAD); rd_q.push_back(16'hF00D);
    exp_beat(0, 32'h300, 16'h0); exp_beat(0, 32'h302, 16'h0);
    n = 0;
    while (bus.mem_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
      if (bus.d_ack === 1'b1) saw_dack = 1;
    end
    vectors++;
    if (n !== DRAIN + 1) begin
      miscompares++;
      $display("FAIL mid_drain: first beat %0d cycles after reset, required %0d", n, DRAIN + 1);
    end
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1; n++;
      if (bus.d_ack === 1'b1) saw_dack = 1;
      if (bus.i_ack === 1'b1) got = 1;
    end
    vectors++;
    if (!got || bus.i_rdata !== 32'hF00D0BAD) begin
      miscompares++;
      $display("FAIL mid_fetch: ack=%0b rdata=%h, required ack=1 rdata=f00d0bad", got, bus.i_rdata);
    end
    bus.i_req = 1'b0;
    vectors++;
    if (saw_dack) begin
      miscompares++;
      $display("FAIL mid_no_dack: d_ack seen for aborted write, required none");
    end
    $display("txn reset_mid: fetch served, rdata %h", bus.i_rdata);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_rw = 0; bus.d_size = 0; bus.d_addr = 0; bus.d_wdata = 0;
    test_reset();
    test_fetch();
    test_writes();
    test_reads();
    test_stale_done();
    test_back_to_back();
    test_reset_mid();
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() !== 0) begin
      miscompares++;
      $display("FAIL leftover_beats: %0d expected beats never issued, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
